// File: rtl/seek_f_pipe.sv
// Multi-lane seek_f offset: f = ((e_top + e_low) << SHIFT) - e_top - c_top, mod 2^OW.
// Two-stage valid/ready pipeline with full backpressure and a delivered-beat counter.

module seek_f_lane #(
    parameter int DW    = 15,
    parameter int SHIFT = 20,
    parameter int OW    = DW + 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld1,
    input  logic          ld2,
    input  logic          mode,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] e,
    output logic [OW-1:0] f
);
    logic [DW-2:0] s_d, s_q;
    logic [2:0]    k_d, k_q;
    logic [OW-1:0] f_d, f_q;

    always_comb begin
        s_d = s_q;
        k_d = k_q;
        f_d = f_q;
        if (ld1) begin
            // s is one bit wider than the low field, so the carry-in never overflows
            s_d = {1'b0, e[DW-3:0]} + {{(DW-2){1'b0}}, e[DW-2]};
            k_d = mode ? 3'd0 : {2'b00, e[DW-2]} + {1'b0, c[DW-1:DW-2]};
        end
        if (ld2)
            f_d = (OW'(s_q) << SHIFT) - OW'(k_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= '0;
            k_q <= '0;
            f_q <= '0;
        end else begin
            s_q <= s_d;
            k_q <= k_d;
            f_q <= f_d;
        end
    end

    assign f = f_q;
endmodule

module seek_f_pipe #(
    parameter int DW    = 15,
    parameter int SHIFT = 20,
    parameter int OW    = DW + 3,
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [LANES*DW-1:0]   in_c,
    input  logic [LANES*DW-1:0]   in_e,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OW-1:0]   out_f,
    output logic [15:0]           beat_cnt
);
    // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = output stage occupied
    logic [2:1]  vld_pipe_d, vld_pipe_q;
    logic [15:0] beat_cnt_d, beat_cnt_q;
    logic        ld1, ld2;

    always_comb begin
        ld2        = !vld_pipe_q[2] || out_ready;
        in_ready   = !vld_pipe_q[1] || ld2;
        ld1        = in_valid && in_ready;
        vld_pipe_d = vld_pipe_q;
        if (in_ready)
            vld_pipe_d[1] = in_valid;
        if (ld2)
            vld_pipe_d[2] = vld_pipe_q[1];
        beat_cnt_d = beat_cnt_q + 16'(vld_pipe_q[2] && out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        seek_f_lane #(.DW(DW), .SHIFT(SHIFT), .OW(OW)) u_lane (
            .clk   (clk),
            .reset (reset),
            .ld1   (ld1),
            .ld2   (ld2 && vld_pipe_q[1]),
            .mode  (in_mode),
            .c     (in_c[i*DW +: DW]),
            .e     (in_e[i*DW +: DW]),
            .f     (out_f[i*OW +: OW])
        );
    end

    assign out_valid = vld_pipe_q[2];
    assign beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_seek_f_pipe.sv
// Bench for seek_f_pipe: default-width and OW=40 instances share stimulus; a queue
// scoreboard checks every delivered beat, in_ready and beat_cnt each cycle.

module tb_seek_f_pipe;
    localparam int DW    = 15;
    localparam int LANES = 4;
    localparam int OW0   = DW + 3;
    localparam int OW1   = 40;
    localparam int NV    = 8;

    typedef struct {
        logic                 mode;
        logic [LANES*DW-1:0]  c;
        logic [LANES*DW-1:0]  e;
        logic [LANES*OW0-1:0] f0;
        logic [LANES*OW1-1:0] f1;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset, in_valid, in_mode, out_ready;
    logic [LANES*DW-1:0]  in_c, in_e;
    logic                 in_ready0, in_ready1, out_valid0, out_valid1;
    logic [LANES*OW0-1:0] out_f0;
    logic [LANES*OW1-1:0] out_f1;
    logic [15:0]          beat_cnt0, beat_cnt1;

    vec_t                 tbl [NV];
    vec_t                 cur;
    logic [LANES*OW0-1:0] q0 [$];
    logic [LANES*OW1-1:0] q1 [$];
    logic [15:0]          exp_cnt;
    int                   n_chk, n_fail, acc_cnt, cyc, bp_ph, c0;
    logic                 bp_en;
    logic [3:0]           bp_pat;

    always #5 clk = ~clk;

    seek_f_pipe u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_mode(in_mode), .in_c(in_c), .in_e(in_e), .out_valid(out_valid0),
        .out_ready(out_ready), .out_f(out_f0), .beat_cnt(beat_cnt0)
    );

    seek_f_pipe #(.OW(OW1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_mode(in_mode), .in_c(in_c), .in_e(in_e), .out_valid(out_valid1),
        .out_ready(out_ready), .out_f(out_f1), .beat_cnt(beat_cnt1)
    );

    function automatic logic [63:0] ref_f(input logic [DW-1:0] e, input logic [DW-1:0] c,
                                          input logic mode, input int ow);
        logic [63:0] s, k, r;
        s = 64'(e[DW-2]) + 64'(e[DW-3:0]);
        k = mode ? 64'd0 : 64'(e[DW-2]) + 64'(c[DW-1:DW-2]);
        r = (s << 20) - k;
        if (ow < 64)
            r = r & ((64'd1 << ow) - 64'd1);
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic exp_rdy;
        if (reset) begin
            q0.delete();
            q1.delete();
            exp_cnt = '0;
            return;
        end
        check("beat_cnt0", beat_cnt0, exp_cnt);
        check("beat_cnt1", beat_cnt1, exp_cnt);
        exp_rdy = !(q0.size() == 2 && !out_ready);
        check("in_ready0", in_ready0, exp_rdy);
        check("in_ready1", in_ready1, exp_rdy);
        if (out_valid0) begin
            if (q0.size() == 0)
                check("spurious0", out_valid0, 1'b0);
            else begin
                check("f0", out_f0, q0[0]);
                if (out_ready) begin
                    void'(q0.pop_front());
                    exp_cnt++;
                end
            end
        end
        if (out_valid1) begin
            if (q1.size() == 0)
                check("spurious1", out_valid1, 1'b0);
            else begin
                check("f1", out_f1, q1[0]);
                if (out_ready)
                    void'(q1.pop_front());
            end
        end
        if (in_valid && exp_rdy) begin
            q0.push_back(cur.f0);
            q1.push_back(cur.f1);
            acc_cnt++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (bp_en) begin
            out_ready = bp_pat[bp_ph];
            bp_ph     = (bp_ph + 1) % 4;
        end
    endtask

    task automatic drive(input vec_t v);
        cur      = v;
        in_mode  = v.mode;
        in_c     = v.c;
        in_e     = v.e;
        in_valid = 1'b1;
    endtask

    task automatic send(input vec_t v);
        int a0;
        a0 = acc_cnt;
        drive(v);
        for (int i = 0; i < 50 && acc_cnt == a0; i++)
            cycle();
        if (acc_cnt == a0) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: beat not accepted in 50 cycles, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q0.size() != 0; i++)
            cycle();
        if (q0.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q0.size());
        end
    endtask

    // Pipeline must be empty and out_ready high on entry
    task automatic lat_check(input vec_t v);
        int a0;
        a0 = acc_cnt;
        drive(v);
        cycle();
        in_valid = 1'b0;
        check("lat_accept", 32'(acc_cnt - a0), 32'd1);
        check("lat_edge_n", out_valid0, 1'b0);
        cycle();
        check("lat_edge_n1_0", out_valid0, 1'b1);
        check("lat_edge_n1_1", out_valid1, 1'b1);
        cycle();
        check("bubble", out_valid0, 1'b0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; acc_cnt = 0; cyc = 0; bp_ph = 0; c0 = 0;
        bp_en = 1'b0; bp_pat = 4'b1001; exp_cnt = '0;
        reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_c = '0; in_e = '0;
        cur = '{default:'0};

        for (int i = 0; i < NV; i++)
            tbl[i] = '{default:'0};
        tbl[0].e[0 +: DW]   = 15'h2005;
        tbl[0].c[0 +: DW]   = 15'h6000;
        tbl[0].f0[0 +: OW0] = 18'h3FFFC;
        tbl[0].f1[0 +: OW1] = 40'h5FFFFC;
        tbl[1]              = tbl[0];
        tbl[1].mode         = 1'b1;
        tbl[1].f0           = '0;
        tbl[1].f1[0 +: OW1] = 40'h600000;
        tbl[2].e[0*DW +: DW] = 15'h1FFF; tbl[2].c[0*DW +: DW] = 15'h7FFF;
        tbl[2].e[1*DW +: DW] = 15'h2000; tbl[2].c[1*DW +: DW] = 15'h0000;
        tbl[2].e[2*DW +: DW] = 15'h3FFF; tbl[2].c[2*DW +: DW] = 15'h2000;
        tbl[2].e[3*DW +: DW] = 15'h0001; tbl[2].c[3*DW +: DW] = 15'h4000;
        tbl[2].f1[0*OW1 +: OW1] = 40'h1FFEFFFFD; tbl[2].f0[0*OW0 +: OW0] = 18'h3FFFD;
        tbl[2].f1[1*OW1 +: OW1] = 40'h0000FFFFF; tbl[2].f0[1*OW0 +: OW0] = 18'h3FFFF;
        tbl[2].f1[2*OW1 +: OW1] = 40'h1FFFFFFFE; tbl[2].f0[2*OW0 +: OW0] = 18'h3FFFE;
        tbl[2].f1[3*OW1 +: OW1] = 40'h0000FFFFE; tbl[2].f0[3*OW0 +: OW0] = 18'h3FFFE;
        for (int i = 4; i < NV; i++) begin
            tbl[i].mode = 1'($urandom);
            for (int l = 0; l < LANES; l++) begin
                tbl[i].e[l*DW +: DW]   = DW'($urandom);
                tbl[i].c[l*DW +: DW]   = DW'($urandom);
                tbl[i].f0[l*OW0 +: OW0] = OW0'(ref_f(tbl[i].e[l*DW +: DW], tbl[i].c[l*DW +: DW], tbl[i].mode, OW0));
                tbl[i].f1[l*OW1 +: OW1] = OW1'(ref_f(tbl[i].e[l*DW +: DW], tbl[i].c[l*DW +: DW], tbl[i].mode, OW1));
            end
        end

        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_mode   = 1'($urandom);
            out_ready = 1'($urandom);
            for (int l = 0; l < LANES; l++) begin
                in_c[l*DW +: DW] = DW'($urandom);
                in_e[l*DW +: DW] = DW'($urandom);
            end
            cycle();
        end
        check("rst_out_valid", {out_valid1, out_valid0}, 2'b00);
        check("rst_out_f0", out_f0, '0);
        check("rst_out_f1", out_f1, '0);
        check("rst_beat_cnt", {beat_cnt1, beat_cnt0}, 32'd0);
        check("rst_in_ready", {in_ready1, in_ready0}, 2'b11);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();

        lat_check(tbl[0]);

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bp_en = 1'b1;
        bp_ph = 0;
        for (int i = 0; i < NV; i++)
            send(tbl[i]);
        bp_en = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_beat_cnt0", beat_cnt0, 16'd8);
        check("bp_beat_cnt1", beat_cnt1, 16'd8);

        c0 = cyc;
        for (int i = 0; i < NV; i++)
            send(tbl[i]);
        check("throughput", 32'(cyc - c0), 32'(NV));
        drain();

        out_ready = 1'b0;
        send(tbl[2]);
        send(tbl[3]);
        check("full_stall_rdy", {in_ready1, in_ready0}, 2'b00);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_valid", {out_valid1, out_valid0}, 2'b00);
        check("mid_rst_cnt", beat_cnt0, 16'd0);
        out_ready = 1'b1;
        cycle();
        lat_check(tbl[1]);
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
